fifo_sync_ctrl: RTL and testbench

Single-clock, parametrised FIFO that succeeds the fixed 16x512 buffer. It has configurable width and depth, an exact occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. A compile-time first-word-fall-through read mode is available. It sits between a producer and a consumer in the `clk_a` domain and serves as the team's general-purpose elastic buffer.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_sync_ctrl_if.sv | 37 +++
 rtl/fifo_mem.sv | 23 ++
 rtl/fifo_sync_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_sync_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 512;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent the completely full state.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer handshake and status bundle for fifo_sync_ctrl.
interface fifo_sync_ctrl_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] din_a;
  logic                  wen_a;
  logic                  ren_b;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] dout_b;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din_a, wen_a, ren_b, err_clr,
    input  dout_b, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  din_a, wen_a, ren_b, err_clr,
    output dout_b, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module fifo_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_a,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk_a) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags
// and sticky errors. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL   = FIFO_DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic            clk_a,
  input  logic            rst,
  fifo_sync_ctrl_if.slave bus
);

  localparam int ADDR_W = addr_w(FIFO_DEPTH);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);

  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_re;
  logic [ADDR_W-1:0]     mem_raddr;
  logic [FIFO_WIDTH-1:0] mem_q;
  fifo_status_t          status;

  always_comb begin
    status.full         = (count_r == CNT_W'(FIFO_DEPTH));
    status.empty        = (count_r == '0);
    status.almost_full  = (count_r >= CNT_W'(AF_LEVEL));
    status.almost_empty = (count_r <= CNT_W'(AE_LEVEL));
    status.overflow     = overflow_r;
    status.underflow    = underflow_r;
  end

  // Acceptance is judged on registered flags; nothing is accepted in a reset cycle.
  assign wr_acc = bus.wen_a & ~status.full  & ~rst;
  assign rd_acc = bus.ren_b & ~status.empty & ~rst;

  always_ff @(posedge clk_a) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      // A set event in the same cycle as err_clr keeps the flag high.
      overflow_r  <= (bus.wen_a & status.full)  | (overflow_r  & ~bus.err_clr);
      underflow_r <= (bus.ren_b & status.empty) | (underflow_r & ~bus.err_clr);
    end
  end

  fifo_mem #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_mem (
    .clk_a(clk_a),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(bus.din_a),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_q)
  );

`ifdef FIFO_FWFT_EN
  // The RAM read register doubles as the prefetched head; fetch_ptr tracks what it holds.
  logic [ADDR_W:0] fetch_ptr;
  logic            head_vld;
  logic            skip;

  assign skip      = rd_acc & ~head_vld;
  assign mem_re    = (fetch_ptr != wr_ptr) & (~head_vld | rd_acc) & ~skip & ~rst;
  assign mem_raddr = fetch_ptr[ADDR_W-1:0];

  always_ff @(posedge clk_a) begin
    if (rst) begin
      fetch_ptr <= '0;
      head_vld  <= 1'b0;
    end else begin
      if (skip | mem_re) fetch_ptr <= fetch_ptr + 1'b1;
      if (mem_re)        head_vld  <= 1'b1;
      else if (rd_acc)   head_vld  <= 1'b0;
    end
  end

  assign bus.dout_b     = head_vld ? mem_q : '0;
  assign bus.dout_valid = ~status.empty;
`else
  logic loaded;
  logic dout_valid_r;

  assign mem_re    = rd_acc;
  assign mem_raddr = rd_ptr[ADDR_W-1:0];

  // The RAM output is not reset, so it is masked until the first accepted read.
  always_ff @(posedge clk_a) begin
    if (rst) begin
      loaded       <= 1'b0;
      dout_valid_r <= 1'b0;
    end else begin
      if (rd_acc) loaded <= 1'b1;
      dout_valid_r <= rd_acc;
    end
  end

  assign bus.dout_b     = loaded ? mem_q : '0;
  assign bus.dout_valid = dout_valid_r;
`endif

  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;
  assign bus.count        = count_r;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl (depth 8, width 16, AF 6, AE 2); honours FIFO_FWFT_EN.
module tb_fifo_sync_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_ctrl_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) bus ();

  fifo_sync_ctrl #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(8),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk_a(clk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen_a   = 1'b0;
    bus.ren_b   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    bus.din_a = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_empty", 32'(bus.empty), 1);
    check_eq("rst_full", 32'(bus.full), 0);
    check_eq("rst_ae", 32'(bus.almost_empty), 1);
    check_eq("rst_af", 32'(bus.almost_full), 0);
    check_eq("rst_dvalid", 32'(bus.dout_valid), 0);
    check_eq("rst_dout", 32'(bus.dout_b), 0);
    check_eq("rst_ovf", 32'(bus.overflow), 0);
    check_eq("rst_unf", 32'(bus.underflow), 0);

    // Fill 0x0001..0x0008.
    for (int i = 1; i <= 8; i++) begin
      bus.din_a = 16'(i);
      bus.wen_a = 1'b1;
      step();
      check_eq("fill_count", 32'(bus.count), 32'(i));
      check_eq("fill_ae", 32'(bus.almost_empty), 32'(i <= 2));
      check_eq("fill_af", 32'(bus.almost_full), 32'(i >= 6));
      check_eq("fill_full", 32'(bus.full), 32'(i == 8));
    end

    // Write while full.
    bus.din_a = 16'hDEAD;
    step();
    idle();
    check_eq("ovf_set", 32'(bus.overflow), 1);
    check_eq("ovf_count", 32'(bus.count), 8);
    bus.err_clr = 1'b1;
    step();
    idle();
    check_eq("ovf_clr", 32'(bus.overflow), 0);

    // Simultaneous read and write at full: read wins, write dropped.
    bus.wen_a = 1'b1;
    bus.ren_b = 1'b1;
    bus.din_a = 16'hDEAD;
    step();
    idle();
    check_eq("rw_full_count", 32'(bus.count), 7);
    check_eq("rw_full_ovf", 32'(bus.overflow), 1);
`ifdef FIFO_FWFT_EN
    check_eq("rw_full_head", 32'(bus.dout_b), 32'h0002);
`else
    check_eq("rw_full_dout", 32'(bus.dout_b), 32'h0001);
    check_eq("rw_full_dvalid", 32'(bus.dout_valid), 1);
`endif
    bus.err_clr = 1'b1;
    step();
    idle();

    // Drain the remaining seven words.
    bus.ren_b = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      step();
      check_eq("rd_count", 32'(bus.count), 32'(8 - i));
`ifdef FIFO_FWFT_EN
      if (i < 8) check_eq("rd_head", 32'(bus.dout_b), 32'(i + 1));
`else
      check_eq("rd_dout", 32'(bus.dout_b), 32'(i));
      check_eq("rd_dvalid", 32'(bus.dout_valid), 1);
`endif
    end
    idle();
    step();
    check_eq("drain_empty", 32'(bus.empty), 1);
    check_eq("drain_dvalid", 32'(bus.dout_valid), 0);
`ifndef FIFO_FWFT_EN
    check_eq("drain_hold", 32'(bus.dout_b), 32'h0008);
`endif

    // Read while empty.
    bus.ren_b = 1'b1;
    step();
    idle();
    check_eq("unf_set", 32'(bus.underflow), 1);
    check_eq("unf_count", 32'(bus.count), 0);
`ifndef FIFO_FWFT_EN
    check_eq("unf_dout_hold", 32'(bus.dout_b), 32'h0008);
`endif
    bus.ren_b   = 1'b1;
    bus.err_clr = 1'b1;
    step();
    idle();
    check_eq("unf_set_wins", 32'(bus.underflow), 1);
    bus.err_clr = 1'b1;
    step();
    idle();
    check_eq("unf_clr", 32'(bus.underflow), 0);

`ifdef FIFO_FWFT_EN
    // Fall-through: word written at edge k visible after edge k+1 without a read.
    bus.din_a = 16'h00AA;
    bus.wen_a = 1'b1;
    step();
    idle();
    check_eq("fwft_count", 32'(bus.count), 1);
    step();
    check_eq("fwft_dout", 32'(bus.dout_b), 32'h00AA);
    check_eq("fwft_dvalid", 32'(bus.dout_valid), 1);
    bus.ren_b = 1'b1;
    step();
    idle();
    check_eq("fwft_pop_empty", 32'(bus.empty), 1);
    check_eq("fwft_pop_dvalid", 32'(bus.dout_valid), 0);
`else
    // Steady state at count 4 across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      bus.din_a = 16'(16'h0100 + i);
      bus.wen_a = 1'b1;
      step();
    end
    check_eq("ss_prefill", 32'(bus.count), 4);
    bus.ren_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.din_a = 16'(16'h0104 + i);
      step();
      check_eq("ss_count", 32'(bus.count), 4);
      check_eq("ss_dout", 32'(bus.dout_b), 32'(16'h0100 + i));
    end
    idle();
`endif

    // Reset mid-stream at count 5 with a write pending.
    for (int i = 0; i < 8; i++) begin
      if (bus.count < 5) begin
        bus.din_a = 16'(16'h0200 + i);
        bus.wen_a = 1'b1;
        step();
        idle();
      end
    end
    check_eq("pre_rst_count", 32'(bus.count), 5);
    rst       = 1'b1;
    bus.wen_a = 1'b1;
    bus.din_a = 16'hBEEF;
    step();
    rst = 1'b0;
    idle();
    check_eq("mid_rst_count", 32'(bus.count), 0);
    check_eq("mid_rst_empty", 32'(bus.empty), 1);
    check_eq("mid_rst_dvalid", 32'(bus.dout_valid), 0);
    check_eq("mid_rst_dout", 32'(bus.dout_b), 0);
    step();
    check_eq("mid_rst_nowrite", 32'(bus.count), 0);

    // Fresh word after reset comes back first.
    bus.din_a = 16'h0055;
    bus.wen_a = 1'b1;
    step();
    idle();
`ifdef FIFO_FWFT_EN
    step();
    check_eq("post_rst_head", 32'(bus.dout_b), 32'h0055);
`else
    bus.ren_b = 1'b1;
    step();
    idle();
    check_eq("post_rst_dout", 32'(bus.dout_b), 32'h0055);
    check_eq("post_rst_empty", 32'(bus.empty), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
